systolic_operand_feeder: RTL

SYSTOLIC_OPERAND_FEEDER -- requirements
Module: systolic_operand_feeder

---
 rtl/systolic_operand_feeder_if.sv | 14 +
 rtl/systolic_operand_feeder.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/systolic_operand_feeder_if.sv
// Operand write channel into the systolic operand feeder (one A column + one B row per beat).
// Ports: wr_valid, wr_a, wr_b driven by the producer; wr_ready returned by the feeder.
// A beat transfers on wr_valid && wr_ready; the feeder holds wr_ready low outside tile loading.
interface systolic_operand_feeder_if #(
  parameter int N = 4
);
  logic           wr_valid;
  logic           wr_ready;
  logic [N*8-1:0] wr_a;
  logic [N*8-1:0] wr_b;

  modport master (output wr_valid, output wr_a, output wr_b, input wr_ready);
  modport slave  (input wr_valid, input wr_a, input wr_b, output wr_ready);
endinterface

// File: rtl/systolic_operand_feeder.sv
// Buffers K operand beats, then streams skewed A/B lanes and diagonal push strobes into an NxN systolic array.
// Latency: first STREAM cycle follows the edge accepting the last beat; STREAM is k_len+2N-2 cycles, then a 1-cycle done.
// Backpressure: wr_ready is high only while loading; start is ignored unless idle with 1 <= k_len <= DEPTH.
// Ports: clk, reset (async active-low), start/k_len, wr (operand channel), a_out/b_out/push_diag, busy, done.
// Optional: FEEDER_TILE_CNT_EN adds a 16-bit wrapping tile_cnt output counting completed tiles.
module systolic_operand_feeder #(
  parameter int N     = 4,
  parameter int DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [4:0]                k_len,
  systolic_operand_feeder_if.slave  wr,
  output logic [N*8-1:0]            a_out,
  output logic [N*8-1:0]            b_out,
  output logic [2*N-2:0]            push_diag,
  output logic                      busy,
  output logic                      done
`ifdef FEEDER_TILE_CNT_EN
  ,
  output logic [15:0]               tile_cnt
`endif
);

  localparam int KW = 5;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = $clog2(DEPTH + 2*N);
  localparam logic [KW-1:0] DEPTH_K  = KW'(DEPTH);
  // Last stream index is k_len + 2N - 3; the offset part is a constant.
  localparam logic [SW-1:0] LAST_OFS = SW'(2*N - 3);

  typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} state_t;

  state_t         state, state_nxt;
  logic [KW-1:0]  k_q, k_nxt;
  logic [KW-1:0]  wptr, wptr_nxt;
  logic [SW-1:0]  s, s_nxt;
  logic [N*8-1:0] a_nxt, b_nxt;
  logic [2*N-2:0] push_nxt;
  logic           wr_fire;

  logic [N*8-1:0] mem_a [DEPTH];
  logic [N*8-1:0] mem_b [DEPTH];

  assign wr.wr_ready = (state == LOAD);
  assign wr_fire     = wr.wr_valid && wr.wr_ready;
  assign busy        = (state == LOAD) || (state == STREAM);
  assign done        = (state == DONE);

  // State register plus registered array-facing outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      k_q       <= '0;
      wptr      <= '0;
      s         <= '0;
      a_out     <= '0;
      b_out     <= '0;
      push_diag <= '0;
    end else begin
      state     <= state_nxt;
      k_q       <= k_nxt;
      wptr      <= wptr_nxt;
      s         <= s_nxt;
      a_out     <= a_nxt;
      b_out     <= b_nxt;
      push_diag <= push_nxt;
    end
  end

  // Operand buffer: no reset needed, entries are only read below the current tile's k_len.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_a[wptr[AW-1:0]] <= wr.wr_a;
      mem_b[wptr[AW-1:0]] <= wr.wr_b;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    k_nxt     = k_q;
    wptr_nxt  = wptr;
    s_nxt     = s;
    case (state)
      IDLE: begin
        if (start && (k_len != '0) && (k_len <= DEPTH_K)) begin
          state_nxt = LOAD;
          k_nxt     = k_len;
          wptr_nxt  = '0;
          s_nxt     = '0;
        end
      end
      LOAD: begin
        if (wr_fire) begin
          wptr_nxt = wptr + KW'(1);
          if (wptr + KW'(1) == k_q) begin
            state_nxt = STREAM;
            s_nxt     = '0;
          end
        end
      end
      STREAM: begin
        if (s == SW'(k_q) + LAST_OFS) begin
          state_nxt = DONE;
          s_nxt     = '0;
        end else begin
          s_nxt = s + SW'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic, computed for the upcoming cycle so the outputs can be registered.
  // The beat accepted on the LOAD->STREAM edge is not yet in the buffer, so it is
  // forwarded straight from the write channel (only matters for k_len == 1).
  always_comb begin
    a_nxt    = '0;
    b_nxt    = '0;
    push_nxt = '0;
    if (state_nxt == STREAM) begin
      for (int i = 0; i < N; i++) begin
        if ((int'(s_nxt) >= i) && (int'(s_nxt) - i < int'(k_nxt))) begin
          if (wr_fire && (int'(wptr) == int'(s_nxt) - i)) begin
            a_nxt[8*i +: 8] = wr.wr_a[8*i +: 8];
            b_nxt[8*i +: 8] = wr.wr_b[8*i +: 8];
          end else begin
            a_nxt[8*i +: 8] = mem_a[AW'(int'(s_nxt) - i)][8*i +: 8];
            b_nxt[8*i +: 8] = mem_b[AW'(int'(s_nxt) - i)][8*i +: 8];
          end
        end
      end
      // Diagonal d sees its first product (k = 0) at stream index d.
      for (int d = 0; d < 2*N-1; d++) begin
        push_nxt[d] = (int'(s_nxt) == d);
      end
    end
  end

`ifdef FEEDER_TILE_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tile_cnt <= '0;
    end else if (state == DONE) begin
      tile_cnt <= tile_cnt + 16'd1;
    end
  end
`endif

endmodule
